eth_mac_filter: RTL and testbench

//  Ethernet receive stage directly downstream of the bitorder stage. It consumes the MSB-first
//  N-bit chunk stream produced there. It checks the 48-bit destination MAC against this

---
 rtl/eth_pkg.sv | 17 +
 rtl/eth_mac_filter.sv | 134 +++++++++++++
 tb/tb_eth_mac_filter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet receive-path types and constants.
// Used by bitorder, mac filter, checksum and aggregate stages.
package eth_pkg;

   typedef enum logic [2:0] {
      DEST,
      SRC,
      TYPE,
      PAYLOAD,
      DROP
   } filt_state_t;

   localparam int          MAC_BITS      = 48;
   localparam int          TYPE_BITS     = 16;
   localparam logic [47:0] MAC_BROADCAST = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/eth_mac_filter.sv
// Destination MAC filter: drops frames not addressed to this node
// or broadcast, strips the 14-byte header, forwards payload + FCS.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   axiiv      input chunk valid (one contiguous run per frame)
//   axiid      input chunk, MSB-first, N bits
//   axiov      output payload chunk valid (1-cycle latency)
//   axiod      output payload chunk (zero when not valid)
//   frame_drop one-cycle pulse when the destination mismatches
module eth_mac_filter
   import eth_pkg::*;
#(
   parameter int          N      = 2,
   parameter logic [47:0] MY_MAC = 48'h69_69_5A_06_54_91
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         axiiv,
   input  logic [N-1:0] axiid,
   output logic         axiov,
   output logic [N-1:0] axiod,
   output logic         frame_drop
);

   localparam int DEST_CH = MAC_BITS / N;
   localparam int SRC_CH  = MAC_BITS / N;
   localparam int TYPE_CH = TYPE_BITS / N;
   localparam int CW      = $clog2(DEST_CH + 1);

   typedef logic [CW-1:0] cnt_t;

   filt_state_t  state, state_n;
   cnt_t         cnt, cnt_n;
   logic         my_match, my_match_n;
   logic         bc_match, bc_match_n;
   logic         armed, armed_n;
   logic         axiov_n;
   logic [N-1:0] axiod_n;
   logic         drop_n;
   logic [N-1:0] mac_chunk;
   logic         my_c, bc_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= DEST;
         cnt        <= '0;
         my_match   <= 1'b1;
         bc_match   <= 1'b1;
         // A reset in the middle of a frame must not let the
         // tail of that frame be parsed as a new header.
         armed      <= ~axiiv;
         axiov      <= 1'b0;
         axiod      <= '0;
         frame_drop <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         my_match   <= my_match_n;
         bc_match   <= bc_match_n;
         armed      <= armed_n;
         axiov      <= axiov_n;
         axiod      <= axiod_n;
         frame_drop <= drop_n;
      end
   end

   assign mac_chunk = MY_MAC[MAC_BITS-1-int'(cnt)*N -: N];
   assign my_c      = my_match & (axiid == mac_chunk);
   assign bc_c      = bc_match & (&axiid);

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      my_match_n = my_match;
      bc_match_n = bc_match;
      armed_n    = armed | ~axiiv;
      axiov_n    = 1'b0;
      axiod_n    = '0;
      drop_n     = 1'b0;
      if (!axiiv) begin
         state_n    = DEST;
         cnt_n      = '0;
         my_match_n = 1'b1;
         bc_match_n = 1'b1;
      end else if (armed) begin
         unique case (state)
            DEST: begin
               my_match_n = my_c;
               bc_match_n = bc_c;
               if (cnt == cnt_t'(DEST_CH - 1)) begin
                  cnt_n = '0;
                  if (my_c | bc_c) begin
                     state_n = SRC;
                  end else begin
                     state_n = DROP;
                     drop_n  = 1'b1;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            SRC: begin
               if (cnt == cnt_t'(SRC_CH - 1)) begin
                  cnt_n   = '0;
                  state_n = TYPE;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            TYPE: begin
               if (cnt == cnt_t'(TYPE_CH - 1)) begin
                  cnt_n   = '0;
                  state_n = PAYLOAD;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            PAYLOAD: begin
               axiov_n = 1'b1;
               axiod_n = axiid;
            end
            DROP: begin
               state_n = DROP;
            end
            default: begin
               state_n = DEST;
               cnt_n   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eth_mac_filter.sv
// Self-checking bench for eth_mac_filter at N=2 and N=4.
// Table of frames plus reset and abort sequences, queue scoreboard.
module tb_eth_mac_filter;

   localparam logic [47:0] MAC = 48'h69_69_5A_06_54_91;

   typedef struct {
      int       cyc;
      logic [3:0] d;
   } ev_t;

   typedef struct {
      logic [47:0] dest;
      logic [31:0] pay;
      int          npay;
      int          cut;
      bit          acc;
      bit          drp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       v2, v4;
   logic [1:0] d2, od2;
   logic [3:0] d4, od4;
   logic       ov2, ov4, fd2, fd4;

   int cyc   = 0;
   int ncmp  = 0;
   int nfail = 0;

   ev_t pq2[$];
   ev_t pq4[$];
   int  dq2[$];
   int  dq4[$];

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   eth_mac_filter #(.N(2), .MY_MAC(MAC)) u2 (
      .clk(clk), .rst(rst), .axiiv(v2), .axiid(d2),
      .axiov(ov2), .axiod(od2), .frame_drop(fd2)
   );

   eth_mac_filter #(.N(4), .MY_MAC(MAC)) u4 (
      .clk(clk), .rst(rst), .axiiv(v4), .axiid(d4),
      .axiov(ov4), .axiod(od4), .frame_drop(fd4)
   );

   task automatic chk(input string nm, input logic [3:0] act,
                      input logic [3:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h",
                  nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (pq2.size() != 0 && pq2[0].cyc == cyc) begin
         ev_t e;
         e = pq2.pop_front();
         chk("n2_axiov", {3'b0, ov2}, 4'd1);
         chk("n2_axiod", {2'b0, od2}, e.d);
      end else if (ov2 === 1'b1) begin
         chk("n2_unexpected_axiov", {3'b0, ov2}, 4'd0);
      end else if (od2 !== 2'b00 && rst === 1'b0) begin
         chk("n2_axiod_idle", {2'b0, od2}, 4'd0);
      end
      if (dq2.size() != 0 && dq2[0] == cyc) begin
         void'(dq2.pop_front());
         chk("n2_frame_drop", {3'b0, fd2}, 4'd1);
      end else if (fd2 === 1'b1) begin
         chk("n2_unexpected_drop", {3'b0, fd2}, 4'd0);
      end
   end

   always @(negedge clk) begin
      if (pq4.size() != 0 && pq4[0].cyc == cyc) begin
         ev_t e;
         e = pq4.pop_front();
         chk("n4_axiov", {3'b0, ov4}, 4'd1);
         chk("n4_axiod", od4, e.d);
      end else if (ov4 === 1'b1) begin
         chk("n4_unexpected_axiov", {3'b0, ov4}, 4'd0);
      end else if (od4 !== 4'h0 && rst === 1'b0) begin
         chk("n4_axiod_idle", od4, 4'd0);
      end
      if (dq4.size() != 0 && dq4[0] == cyc) begin
         void'(dq4.pop_front());
         chk("n4_frame_drop", {3'b0, fd4}, 4'd1);
      end else if (fd4 === 1'b1) begin
         chk("n4_unexpected_drop", {3'b0, fd4}, 4'd0);
      end
   end

   task automatic step(input int n, input logic v, input logic [3:0] d);
      if (n == 2) begin
         v2 = v;
         d2 = d[1:0];
      end else begin
         v4 = v;
         d4 = d;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int n, input vec_t t);
      logic [7:0] bytes[$];
      int         lim, cpb, hdr_ch, dest_ch, mask;
      logic [7:0] b;
      logic [3:0] c;
      for (int i = 0; i < 6; i++) bytes.push_back(t.dest[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) bytes.push_back(8'($urandom));
      bytes.push_back(8'h08);
      bytes.push_back(8'h00);
      for (int i = 0; i < t.npay; i++) bytes.push_back(t.pay[31-8*i -: 8]);
      cpb     = 8 / n;
      hdr_ch  = 14 * cpb;
      dest_ch = 6 * cpb;
      mask    = (1 << n) - 1;
      case (t.cut)
         1:       lim = 10 * cpb;
         2:       lim = hdr_ch + 3;
         3:       lim = 4 * cpb;
         default: lim = bytes.size() * cpb;
      endcase
      for (int j = 0; j < lim; j++) begin
         b = bytes[j / cpb];
         c = 4'((int'(b) >> (8 - n * (j % cpb + 1))) & mask);
         if (t.acc && j >= hdr_ch) begin
            if (n == 2) pq2.push_back('{cyc + 1, c});
            else        pq4.push_back('{cyc + 1, c});
         end
         if (t.drp && j == dest_ch - 1) begin
            if (n == 2) dq2.push_back(cyc + 1);
            else        dq4.push_back(cyc + 1);
         end
         step(n, 1'b1, c);
      end
      step(n, 1'b0, 4'h0);
   endtask

   vec_t tbl[11];

   initial begin
      tbl[0]  = '{MAC,                     32'hA53C_0000, 2, 0, 1, 0};
      tbl[1]  = '{48'hFFFF_FFFF_FFFF,      32'h5A00_0000, 1, 0, 1, 0};
      tbl[2]  = '{MAC ^ 48'h1,             32'h5AA5_0000, 2, 0, 0, 1};
      tbl[3]  = '{MAC,                     32'h0,         0, 1, 1, 0};
      tbl[4]  = '{MAC,                     32'hC300_0000, 1, 0, 1, 0};
      tbl[5]  = '{MAC,                     32'hDEAD_BEEF, 4, 2, 1, 0};
      tbl[6]  = '{MAC,                     32'h1234_0000, 2, 0, 1, 0};
      tbl[7]  = '{MAC ^ 48'h8000_0000_0000, 32'h7700_0000, 1, 0, 0, 1};
      tbl[8]  = '{48'h0102_0304_0506,      32'h0,         0, 1, 0, 1};
      tbl[9]  = '{48'h0102_0304_0506,      32'h0,         0, 3, 0, 0};
      tbl[10] = '{48'hFFFF_FFFF_FFFE,      32'hF0F0_0000, 2, 0, 0, 1};

      rst = 1'b1;
      v2  = 1'b1;
      v4  = 1'b1;
      d2  = 2'($urandom);
      d4  = 4'($urandom);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_axiov_n2", {3'b0, ov2}, 4'd0);
         chk("rst_axiod_n2", {2'b0, od2}, 4'd0);
         chk("rst_drop_n2",  {3'b0, fd2}, 4'd0);
         chk("rst_axiov_n4", {3'b0, ov4}, 4'd0);
         chk("rst_axiod_n4", od4, 4'd0);
         chk("rst_drop_n4",  {3'b0, fd4}, 4'd0);
         d2 = 2'($urandom);
         d4 = 4'($urandom);
      end
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         d2 = 2'($urandom);
         d4 = 4'($urandom);
         @(posedge clk);
         #1;
      end
      v2 = 1'b0;
      v4 = 1'b0;
      d2 = '0;
      d4 = '0;
      repeat (2) @(posedge clk);
      #1;

      foreach (tbl[k]) send_frame(2, tbl[k]);
      repeat (3) step(2, 1'b0, 4'h0);
      foreach (tbl[k]) send_frame(4, tbl[k]);
      repeat (4) step(4, 1'b0, 4'h0);

      chk("n2_payload_all_seen", 4'(pq2.size()), 4'd0);
      chk("n4_payload_all_seen", 4'(pq4.size()), 4'd0);
      chk("n2_drops_all_seen",   4'(dq2.size()), 4'd0);
      chk("n4_drops_all_seen",   4'(dq4.size()), 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               ncmp, nfail);
      $finish;
   end

endmodule
